// File: rtl/div.sv
// rtl/div.sv - 32-bit signed restoring divider, 33-edge latency; optional DIV_ZERO_DETECT_EN
module div (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        start,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        done,
  output logic        div_zero
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  state_t      r_state;
  logic [31:0] r_dvd;   // |a| shifting out MSB first, quotient bits shifting in at LSB
  logic [31:0] r_dsr;   // |b|
  logic [32:0] r_rem;   // partial remainder
  logic        r_sa;
  logic        r_sb;
  logic [5:0]  r_cnt;
  logic [31:0] r_hi;
  logic [31:0] r_lo;
  logic        r_busy;
  logic        r_done;

  logic [31:0] w_a_abs;
  logic [31:0] w_b_abs;
  logic [33:0] w_shift;
  logic [33:0] w_trial;
  logic        w_qbit;

  // Magnitudes of the operands; 0x80000000 maps onto itself, which is the correct unsigned magnitude
  assign w_a_abs = a[31] ? (~a + 32'd1) : a;
  assign w_b_abs = b[31] ? (~b + 32'd1) : b;

  // One restoring step: shift in the next dividend bit, trial-subtract the divisor
  assign w_shift = {r_rem, r_dvd[31]};
  assign w_trial = w_shift - {2'b00, r_dsr};
  assign w_qbit  = ~w_trial[33];

  assign hi   = r_hi;
  assign lo   = r_lo;
  assign busy = r_busy;
  assign done = r_done;

`ifdef DIV_ZERO_DETECT_EN
  logic r_bz;
  logic r_dz;
  assign div_zero = r_dz;
`else
  assign div_zero = 1'b0;
`endif

  // Divider FSM: accept in IDLE, 32 restoring steps in CALC, sign fix-up and result publish in FIX
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_dvd   <= 32'd0;
      r_dsr   <= 32'd0;
      r_rem   <= 33'd0;
      r_sa    <= 1'b0;
      r_sb    <= 1'b0;
      r_cnt   <= 6'd0;
      r_hi    <= 32'd0;
      r_lo    <= 32'd0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
`ifdef DIV_ZERO_DETECT_EN
      r_bz    <= 1'b0;
      r_dz    <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
`ifdef DIV_ZERO_DETECT_EN
      r_dz   <= 1'b0;
`endif
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_dvd   <= w_a_abs;
            r_dsr   <= w_b_abs;
            r_rem   <= 33'd0;
            r_sa    <= a[31];
            r_sb    <= b[31];
            r_cnt   <= 6'd0;
            r_busy  <= 1'b1;
            r_state <= S_CALC;
`ifdef DIV_ZERO_DETECT_EN
            r_bz    <= (b == 32'd0);
`endif
          end
        end
        S_CALC: begin
`ifdef DIV_ZERO_DETECT_EN
          if (r_bz) begin
            r_done  <= 1'b1;
            r_dz    <= 1'b1;
            r_busy  <= 1'b0;
            r_bz    <= 1'b0;
            r_state <= S_IDLE;
          end else begin
`endif
            r_rem   <= w_qbit ? w_trial[32:0] : w_shift[32:0];
            r_dvd   <= {r_dvd[30:0], w_qbit};
            r_cnt   <= r_cnt + 6'd1;
            if (r_cnt == 6'd31) begin
              r_state <= S_FIX;
            end
`ifdef DIV_ZERO_DETECT_EN
          end
`endif
        end
        S_FIX: begin
          r_lo    <= (r_sa ^ r_sb) ? (~r_dvd + 32'd1) : r_dvd;
          r_hi    <= r_sa ? (~r_rem[31:0] + 32'd1) : r_rem[31:0];
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/div.md
DIV -- requirements
Module: div

Interface
REQ-001 Parameters: none; operand and result width SHALL be fixed at 32 bits.
REQ-002 clock  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 reset  input  1  synchronous, active-low reset; sampled on rising edge of clock.
REQ-004 a  input  32  dividend, two's-complement signed; sampled only when start is accepted.
REQ-005 b  input  32  divisor, two's-complement signed; sampled only when start is accepted.
REQ-006 start  input  1  request to begin a division; level-sampled each edge.
REQ-007 hi  output  32  remainder, registered.
REQ-008 lo  output  32  quotient, registered.
REQ-009 busy  output  1  high while a division is in progress.
REQ-010 done  output  1  single-cycle pulse when hi/lo hold a new result.
REQ-011 div_zero  output  1  high with done when the captured b was zero; otherwise low.

Function
REQ-012 States SHALL be IDLE, CALC and FIX, encoded in one state register.
REQ-013 IDLE: start=1 at edge E0 SHALL capture |a|, |b|, sign(a) and sign(b) into internal registers, clear the 6-bit iteration counter, set busy=1 and go to CALC.
REQ-014 CALC: one restoring-division step per edge; 33-bit partial remainder SHALL be shifted left by 1 with the next dividend bit, MSB first; the trial subtract of |b| SHALL commit if non-negative, and the quotient bit SHALL be set accordingly.
REQ-015 CALC SHALL run exactly 32 steps (E1..E32), then go to FIX.
REQ-016 FIX (edge E33): lo SHALL be the quotient, negated if sign(a)!=sign(b); hi SHALL be the remainder, negated if sign(a)=1; done=1 and busy=0 for exactly the cycle after E33; state SHALL return to IDLE.
REQ-017 Total latency SHALL be 33 edges from start acceptance to done; the next start SHALL be accepted at the edge immediately after done rises (back-to-back allowed).
REQ-018 Quotient SHALL truncate toward zero; remainder sign SHALL follow dividend; |hi| < |b|.
REQ-019 a=0x80000000 and b=0xFFFFFFFF SHALL give lo=0x80000000 and hi=0x00000000, with no error flag.
REQ-020 start while busy=1 SHALL be ignored; a/b changes during CALC/FIX SHALL NOT affect the result.
REQ-021 hi/lo SHALL hold their last result until the next FIX (or reset); they SHALL NOT show intermediate values.
REQ-022 done SHALL never be high for two consecutive cycles; busy and done SHALL never be high together.

Reset
REQ-023 reset=0 at any edge SHALL force IDLE, hi=0, lo=0, busy=0, done=0, div_zero=0, and clear the internal registers and counter; it SHALL take priority over start and any in-flight operation.
REQ-024 A division aborted by reset SHALL produce no done pulse.

Configuration
REQ-025 Macro DIV_ZERO_DETECT_EN defined: b=0 at acceptance SHALL skip CALC/FIX; at E1 set done=1, div_zero=1, busy=0, keep hi/lo unchanged and return to IDLE.
REQ-026 Macro undefined: b=0 SHALL take the normal 33-edge path, yielding hi=a and lo=0xFFFFFFFF if a>=0, else lo=0x00000001; div_zero SHALL be tied to 0.

Verification
REQ-027 a=100, b=7, start pulse -> done after 33 edges; lo=0x0000000E, hi=0x00000002, div_zero=0.
REQ-028 a=-100, b=7 -> lo=0xFFFFFFF2, hi=0xFFFFFFFE; a=100, b=-7 -> lo=0xFFFFFFF2, hi=0x00000002.
REQ-029 a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0; then back-to-back start with a=7, b=7 -> lo=1, hi=0, 33 edges later.
REQ-030 b=0, a=5: with DIV_ZERO_DETECT_EN -> done and div_zero at the cycle after E1, hi/lo unchanged; without -> after 33 edges, lo=0xFFFFFFFF, hi=5.
REQ-031 start held high for 40 cycles with a/b toggling after E0 -> exactly one done at E33, result from the E0 operands; the next start is accepted at E34.
REQ-032 reset=0 at E10 of a division -> next cycle all outputs 0, no done pulse; a new start is accepted normally afterward.
